// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - data-memory port arbiter between the nanorv32 core and a host master
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cpu_rd_req/addr, cpu_rd_data    core read request and returned read data
//   cpu_wr_req/addr/data/be         core write request
//   cpu_stall                       core request not serviced this cycle
//   host_req/we/addr/wdata/be       host access request (held until granted)
//   host_gnt                        host access accepted this cycle
//   host_rvalid, host_rdata         host read data, one cycle after a read grant
//   mem_rd_*, mem_wr_*              shared memory read and write ports
//   stall_cnt                       saturating count of stalled core cycles
module dmem_arb #(
    parameter int ADDRWIDTH = 32,
    parameter int MAX_WAIT  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_rd_req,
    input  logic [ADDRWIDTH-1:0] cpu_rd_addr,
    output logic [31:0]          cpu_rd_data,
    input  logic                 cpu_wr_req,
    input  logic [ADDRWIDTH-1:0] cpu_wr_addr,
    input  logic [31:0]          cpu_wr_data,
    input  logic [3:0]           cpu_wr_be,
    output logic                 cpu_stall,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDRWIDTH-1:0] host_addr,
    input  logic [31:0]          host_wdata,
    input  logic [3:0]           host_be,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [31:0]          host_rdata,
    output logic                 mem_rd_req,
    output logic [ADDRWIDTH-1:0] mem_rd_addr,
    input  logic [31:0]          mem_rd_data,
    output logic                 mem_wr_req,
    output logic [ADDRWIDTH-1:0] mem_wr_addr,
    output logic [31:0]          mem_wr_data,
    output logic [3:0]           mem_wr_be,
    output logic [15:0]          stall_cnt
);

    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    owner_t        rd_owner, rd_owner_next;
    logic [WW-1:0] wait_cnt, wait_cnt_next;
    logic [15:0]   stall_q, stall_next;
    logic          cpu_act, contend, host_win, cpu_win;

    // Ownership of this cycle's memory access. Core wins contention until the
    // host has lost MAX_WAIT contested cycles in a row.
    always_comb begin
        cpu_act  = cpu_rd_req | cpu_wr_req;
        contend  = cpu_act & host_req;
        host_win = host_req & (~cpu_act | (wait_cnt >= WAIT_LIMIT));
        cpu_win  = cpu_act & ~host_win;
    end

    // All outputs are gated to zero while reset is high.
    always_comb begin
        cpu_stall   = 1'b0;
        host_gnt    = 1'b0;
        mem_rd_req  = 1'b0;
        mem_rd_addr = '0;
        mem_wr_req  = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_wr_be   = '0;
        cpu_rd_data = '0;
        host_rdata  = '0;
        host_rvalid = 1'b0;
        if (!reset) begin
            if (host_win) begin
                host_gnt  = 1'b1;
                cpu_stall = cpu_act;
                if (host_we) begin
                    mem_wr_req  = 1'b1;
                    mem_wr_addr = host_addr;
                    mem_wr_data = host_wdata;
                    mem_wr_be   = host_be;
                end else begin
                    mem_rd_req  = 1'b1;
                    mem_rd_addr = host_addr;
                end
            end else if (cpu_win) begin
                mem_rd_req  = cpu_rd_req;
                mem_rd_addr = cpu_rd_addr;
                mem_wr_req  = cpu_wr_req;
                mem_wr_addr = cpu_wr_addr;
                mem_wr_data = cpu_wr_data;
                mem_wr_be   = cpu_wr_be;
            end
            case (rd_owner)
                OWN_CPU:  cpu_rd_data = mem_rd_data;
                OWN_HOST: begin
                    host_rdata  = mem_rd_data;
                    host_rvalid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign stall_cnt = stall_q;

    always_comb begin
        rd_owner_next = OWN_IDLE;
        if (host_win && !host_we) begin
            rd_owner_next = OWN_HOST;
        end else if (cpu_win && cpu_rd_req) begin
            rd_owner_next = OWN_CPU;
        end

        // Starvation count: only a contested cycle lost by the host advances it.
        wait_cnt_next = wait_cnt;
        if (host_win || !host_req) begin
            wait_cnt_next = '0;
        end else if (contend && (wait_cnt != WAIT_LIMIT)) begin
            wait_cnt_next = wait_cnt + 1'b1;
        end

        stall_next = stall_q;
        if (cpu_stall && (stall_q != 16'hFFFF)) begin
            stall_next = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner <= OWN_IDLE;
            wait_cnt <= '0;
            stall_q  <= '0;
        end else begin
            rd_owner <= rd_owner_next;
            wait_cnt <= wait_cnt_next;
            stall_q  <= stall_next;
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// tb/tb_dmem_arb.sv - randomized model-checked bench for dmem_arb (MAX_WAIT 3 and 0)
module tb_dmem_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_rd_req, cpu_wr_req, host_req, host_we;
    logic [31:0] cpu_rd_addr, cpu_wr_addr, cpu_wr_data, host_addr, host_wdata;
    logic [3:0]  cpu_wr_be, host_be;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int MW = (g == 0) ? 3 : 0;
        logic [31:0] cpu_rd_data, host_rdata, mem_rd_addr, mem_wr_addr;
        logic [31:0] mem_wr_data, mem_rd_data;
        logic        cpu_stall, host_gnt, host_rvalid, mem_rd_req, mem_wr_req;
        logic [3:0]  mem_wr_be;
        logic [15:0] stall_cnt;

        dmem_arb #(.ADDRWIDTH(32), .MAX_WAIT(MW)) u_dut (
            .clk(clk), .reset(reset),
            .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_data(cpu_rd_data),
            .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
            .cpu_wr_be(cpu_wr_be), .cpu_stall(cpu_stall),
            .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
            .host_wdata(host_wdata), .host_be(host_be), .host_gnt(host_gnt),
            .host_rvalid(host_rvalid), .host_rdata(host_rdata),
            .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
            .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
            .mem_wr_be(mem_wr_be), .stall_cnt(stall_cnt)
        );

        // 16-word RAM behind the memory port, one-cycle read latency.
        logic [31:0] ram [16];
        always @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < 16; i++) ram[i] <= '0;
                mem_rd_data <= '0;
            end else begin
                mem_rd_data <= ram[mem_rd_addr[5:2]];
                if (mem_wr_req) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_wr_be[b]) ram[mem_wr_addr[5:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
                end
            end
        end

        // Reference model: who owns the port, what each master should see.
        int          losses = 0;
        int          owner  = 0;
        int          scnt   = 0;
        logic [31:0] rdval  = '0;
        logic [31:0] mmem [16];
        logic        cact, hw, cw, any_out;
        string       pfx;

        always @(negedge clk) begin
            pfx  = (g == 0) ? "mw3_" : "mw0_";
            cact = cpu_rd_req | cpu_wr_req;
            hw   = host_req && (!cact || losses >= MW);
            cw   = cact && !hw;
            if (reset) begin
                any_out = cpu_stall | host_gnt | host_rvalid | mem_rd_req | mem_wr_req
                        | (|cpu_rd_data) | (|host_rdata) | (|mem_rd_addr) | (|mem_wr_addr)
                        | (|mem_wr_data) | (|mem_wr_be) | (|stall_cnt);
                chk({pfx, "reset_outputs"}, any_out, 0);
                losses = 0; owner = 0; scnt = 0; rdval = '0;
                for (int i = 0; i < 16; i++) mmem[i] = '0;
            end else begin
                chk({pfx, "host_gnt"}, host_gnt, hw);
                chk({pfx, "cpu_stall"}, cpu_stall, hw && cact);
                chk({pfx, "mem_rd_req"}, mem_rd_req, hw ? !host_we : (cw && cpu_rd_req));
                chk({pfx, "mem_wr_req"}, mem_wr_req, hw ? host_we : (cw && cpu_wr_req));
                if (mem_rd_req)
                    chk({pfx, "mem_rd_addr"}, mem_rd_addr, hw ? host_addr : cpu_rd_addr);
                if (mem_wr_req) begin
                    chk({pfx, "mem_wr_addr"}, mem_wr_addr, hw ? host_addr : cpu_wr_addr);
                    chk({pfx, "mem_wr_data"}, mem_wr_data, hw ? host_wdata : cpu_wr_data);
                    chk({pfx, "mem_wr_be"}, mem_wr_be, hw ? host_be : cpu_wr_be);
                end
                chk({pfx, "cpu_rd_data"}, cpu_rd_data, (owner == 1) ? rdval : 32'h0);
                chk({pfx, "host_rdata"}, host_rdata, (owner == 2) ? rdval : 32'h0);
                chk({pfx, "host_rvalid"}, host_rvalid, owner == 2);
                chk({pfx, "stall_cnt"}, stall_cnt, scnt);

                owner = 0;
                if (hw && !host_we) begin
                    owner = 2; rdval = mmem[host_addr[5:2]];
                end else if (cw && cpu_rd_req) begin
                    owner = 1; rdval = mmem[cpu_rd_addr[5:2]];
                end
                for (int b = 0; b < 4; b++) begin
                    if (hw && host_we && host_be[b])
                        mmem[host_addr[5:2]][8*b +: 8] = host_wdata[8*b +: 8];
                    if (cw && cpu_wr_req && cpu_wr_be[b])
                        mmem[cpu_wr_addr[5:2]][8*b +: 8] = cpu_wr_data[8*b +: 8];
                end
                if (hw || !host_req) losses = 0;
                else if (losses < MW) losses = losses + 1;
                if (hw && cact && scnt < 65535) scnt = scnt + 1;
            end
        end
    end

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_rd_req = 0; cpu_wr_req = 0; host_req = 0; host_we = 0;
        cpu_rd_addr = '0; cpu_wr_addr = '0; cpu_wr_data = '0; cpu_wr_be = '0;
        host_addr = '0; host_wdata = '0; host_be = '0;
    endtask

    int   ng3, ng0;
    logic hg, cs;

    initial begin
        idle();
        cpu_rd_req = 1; host_req = 1;
        repeat (2) @(negedge clk);
        chk("rst_gnt", g_dut[0].host_gnt, 0);
        chk("rst_stall", g_dut[0].cpu_stall, 0);
        chk("rst_stall_cnt", g_dut[0].stall_cnt, 0);
        nc();
        reset = 0;
        idle();

        // core write then read back
        cpu_wr_req = 1; cpu_wr_addr = 32'h10; cpu_wr_data = 32'hDEADBEEF; cpu_wr_be = 4'hF;
        @(negedge clk); chk("core_wr_stall", g_dut[0].cpu_stall, 0);
        nc();
        cpu_wr_req = 0; cpu_rd_req = 1; cpu_rd_addr = 32'h10;
        @(negedge clk); chk("core_rd_stall", g_dut[0].cpu_stall, 0);
        nc();
        idle();
        @(negedge clk); chk("core_rd_data", g_dut[0].cpu_rd_data, 32'hDEADBEEF);
        nc();

        // host partial write then read back
        host_req = 1; host_we = 1; host_addr = 32'h20; host_wdata = 32'h12345678; host_be = 4'h3;
        @(negedge clk); chk("host_wr_gnt", g_dut[0].host_gnt, 1);
        nc();
        host_we = 0;
        @(negedge clk); chk("host_rd_gnt", g_dut[0].host_gnt, 1);
        nc();
        idle();
        @(negedge clk);
        chk("host_rvalid", g_dut[0].host_rvalid, 1);
        chk("host_rdata_lo", {16'h0, g_dut[0].host_rdata[15:0]}, 32'h5678);
        nc();

        // continuous contention
        cpu_rd_req = 1; cpu_rd_addr = 32'h10; host_req = 1; host_we = 0; host_addr = 32'h20;
        ng3 = 0; ng0 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 3) chk("cont_gnt_c3", g_dut[0].host_gnt, 0);
            if (c == 4) chk("cont_gnt_c4", g_dut[0].host_gnt, 1);
            if (c == 8) chk("cont_stall_c8", g_dut[0].cpu_stall, 1);
            ng3 += int'(g_dut[0].host_gnt);
            ng0 += int'(g_dut[1].host_gnt);
            nc();
        end
        idle();
        @(negedge clk);
        chk("cont_grants_mw3", ng3, 3);
        chk("cont_stall_cnt_mw3", g_dut[0].stall_cnt, 3);
        chk("cont_grants_mw0", ng0, 12);
        chk("cont_stall_cnt_mw0", g_dut[1].stall_cnt, 12);
        nc();

        // alternating read owners: core, host, core
        cpu_rd_req = 1; cpu_rd_addr = 32'h10;
        nc();
        cpu_rd_req = 0; host_req = 1; host_we = 0; host_addr = 32'h20;
        @(negedge clk);
        chk("alt1_cpu_data", g_dut[0].cpu_rd_data, 32'hDEADBEEF);
        chk("alt1_rvalid", g_dut[0].host_rvalid, 0);
        nc();
        host_req = 0; cpu_rd_req = 1; cpu_rd_addr = 32'h10;
        @(negedge clk);
        chk("alt2_rvalid", g_dut[0].host_rvalid, 1);
        chk("alt2_cpu_data", g_dut[0].cpu_rd_data, 0);
        nc();
        idle();
        @(negedge clk);
        chk("alt3_cpu_data", g_dut[0].cpu_rd_data, 32'hDEADBEEF);
        chk("alt3_rvalid", g_dut[0].host_rvalid, 0);
        nc();

        // reset the cycle after a host read grant
        host_req = 1; host_we = 0; host_addr = 32'h20;
        @(negedge clk); chk("rstrd_gnt", g_dut[0].host_gnt, 1);
        nc();
        reset = 1; host_req = 0;
        @(negedge clk);
        chk("rstrd_rvalid", g_dut[0].host_rvalid, 0);
        chk("rstrd_rdata", g_dut[0].host_rdata, 0);
        nc();
        reset = 0;
        @(negedge clk);
        chk("rstrd_rvalid_after", g_dut[0].host_rvalid, 0);
        chk("rstrd_stall_cnt3", g_dut[0].stall_cnt, 0);
        chk("rstrd_stall_cnt0", g_dut[1].stall_cnt, 0);
        nc();

        // randomized traffic, masters hold requests until serviced by the MAX_WAIT=3 unit
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            hg = g_dut[0].host_gnt;
            cs = g_dut[0].cpu_stall;
            nc();
            if (reset) reset = 0;
            else if ($urandom_range(199) == 0) reset = 1;
            if (!host_req || hg) begin
                host_req   = ($urandom_range(2) != 0);
                host_we    = 1'($urandom);
                host_addr  = 32'($urandom_range(15)) << 2;
                host_wdata = $urandom;
                host_be    = 4'($urandom);
            end
            if (!cs) begin
                cpu_rd_req  = 1'($urandom);
                cpu_wr_req  = 1'($urandom);
                cpu_rd_addr = 32'($urandom_range(15)) << 2;
                cpu_wr_addr = 32'($urandom_range(15)) << 2;
                cpu_wr_data = $urandom;
                cpu_wr_be   = 4'($urandom);
            end
        end
        reset = 0;
        idle();
        nc();

        // saturate the stall counter of the MAX_WAIT=0 unit
        cpu_rd_req = 1; cpu_rd_addr = 32'h4; host_req = 1; host_we = 0; host_addr = 32'h8;
        repeat (65540) nc();
        idle();
        @(negedge clk);
        chk("stall_cnt_saturated", g_dut[1].stall_cnt, 32'hFFFF);
        nc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arb.md
# dmem_arb

Data-memory arbiter that shares the single data-memory port (byte-lane RAM plus the memory-mapped I/O decode) between the nanorv32 core and a host master (loader/debug/DMA). The core has priority by default and the host is guaranteed forward progress by a starvation counter. When the core loses a contested cycle, the block stalls it through the core's `stall` input. Read data is steered back to whichever master owned the read one cycle earlier.

## Interface
- `ADDRWIDTH`, 32: address width of all address ports.
- `MAX_WAIT`, 3: number of consecutive contested cycles the host may lose before it is granted the next one (0 = host always wins contention).
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `cpu_rd_req`  in  1  core read request.
- `cpu_rd_addr`  in  ADDRWIDTH  core read address.
- `cpu_rd_data`  out  32  read data returned to the core.
- `cpu_wr_req`  in  1  core write request.
- `cpu_wr_addr`  in  ADDRWIDTH  core write address.
- `cpu_wr_data`  in  32  core write data.
- `cpu_wr_be`  in  4  core write byte enables.
- `cpu_stall`  out  1  stall to the core; the request is not serviced this cycle.
- `host_req`  in  1  host access request, held until granted.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  ADDRWIDTH  host address.
- `host_wdata`  in  32  host write data.
- `host_be`  in  4  host write byte enables.
- `host_gnt`  out  1  access accepted this cycle.
- `host_rvalid`  out  1  host read data valid, one cycle after a read grant.
- `host_rdata`  out  32  host read data.
- `mem_rd_req`, `mem_rd_addr`  out  1/ADDRWIDTH  memory read port.
- `mem_rd_data`  in  32  memory read data, valid 1 cycle after `mem_rd_req`.
- `mem_wr_req`, `mem_wr_addr`, `mem_wr_data`, `mem_wr_be`  out  1/ADDRWIDTH/32/4  memory write port.
- `stall_cnt`  out  16  saturating count of cycles with `cpu_stall` high.

## Operation
- `cpu_act = cpu_rd_req | cpu_wr_req`. Contention means `cpu_act & host_req`.
- Owner is decided combinationally each cycle:
  - Only the core requests: core wins.
  - Only the host requests: host wins.
  - Contention: host wins if `wait_cnt >= MAX_WAIT`; otherwise the core wins.
- Core win: core read and write requests pass through to the memory ports unchanged. Both may be active in the same cycle. `cpu_stall` = 0.
- Host win: exactly one memory port is driven, the write port if `host_we`, otherwise the read port. `host_gnt` = 1. `cpu_stall` = `cpu_act`.
- The core holds its request stable while stalled. A stalled request is retried automatically in the next cycle.
- `wait_cnt` tracks host starvation:
  - increments, saturating at MAX_WAIT, on each contested cycle the core wins;
  - clears on any host grant or when `host_req` = 0.
- `rd_owner` register (IDLE/CPU/HOST) is loaded each cycle from the owner of any read issued.
  - CPU: `cpu_rd_data` = `mem_rd_data`.
  - HOST: `host_rdata` = `mem_rd_data` and `host_rvalid` = 1.
  - When not owned by the core, `cpu_rd_data` is 0. When not owned by the host, `host_rdata` is 0.
- Host write data is never forwarded to `host_rdata`.
- A host holding `host_req` after a grant is requesting a new access. Back-to-back host grants are allowed when the core is idle.
- `stall_cnt` increments on each cycle with `cpu_stall` = 1 and saturates at 16'hFFFF.

## Timing
- Reset asserted: `wait_cnt`, `rd_owner`, `stall_cnt`, and `host_rvalid` clear immediately. All outputs are forced to 0: grants, stall, memory requests and data. This is a combinational gate on reset.
- Grant, stall, and memory requests are combinational from the same-cycle inputs and registered state: 0-cycle latency.
- Read data latency is 1 cycle after the grant. `host_rvalid` is a single-cycle pulse per read grant.
- Reset mid-read: the pending `host_rvalid` is dropped and is not reissued after reset releases.
- Worst-case host latency under continuous core traffic: MAX_WAIT + 1 cycles from `host_req`.
- Worst-case consecutive core stall under continuous host traffic: 1 cycle per MAX_WAIT + 1 contested cycles. With MAX_WAIT = 0, the host can stall the core indefinitely; this is intended for the loader.

## Test plan
- Core-only traffic. Core writes 0xDEADBEEF with be = 4'hF to 0x10, then reads 0x10. Required: `cpu_stall` = 0 throughout, and `cpu_rd_data` = 0xDEADBEEF one cycle after the read.
- Host-only traffic. Host writes 0x12345678 with be = 4'h3, then reads the same address. Required: `host_gnt` high in both cycles, and `host_rvalid` pulses with 0x????5678 in the low half.
- Continuous contention, MAX_WAIT = 3. Core read every cycle and `host_req` held high. Required: host granted on cycles 4, 8, 12, …; `cpu_stall` high exactly on those cycles; `stall_cnt` = 3 after 12 cycles.
- MAX_WAIT = 0 with contention. Required: host wins every cycle, and `cpu_stall` stays high while `host_req` is high.
- Back-to-back reads alternating owners (core, host, core). Required: each read's data is routed only to its own master; `host_rvalid` is 0 during core-owned data cycles.
- Reset asserted in the cycle after a host read grant. Required: `host_rvalid` never pulses, all counters read 0, and all outputs are 0 while reset is high.
